// File: rtl/rv_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Package    : rv_pipe_pkg
// Purpose    : Shared encodings for the 5-stage RISC-V pipeline. Used by the
//              hazard controller, the execute stage and the decoder.
//              - forwarding-mux select codes (FWD_*)
//              - writeback-select codes (WB_*)
//              - hazard FSM state type
//              - fwd_sel() helper that picks a forwarding source
// Revision   : 1.0 - initial release
// ============================================================================
package rv_pipe_pkg;

  // Execute-stage operand mux selects
  localparam logic [1:0] FWD_REG = 2'b00;  // register-file read value
  localparam logic [1:0] FWD_W   = 2'b01;  // resultW from writeback
  localparam logic [1:0] FWD_M   = 2'b10;  // ALUresM from memory stage

  // Writeback source selects
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_t;

  // The memory stage holds the younger result, so it wins over writeback.
  // x0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       regwrite_m,
    input logic [4:0] rd_w,
    input logic       regwrite_w
  );
    logic [1:0] sel;
    sel = FWD_REG;
    if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_M;
    end else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface  : hazard_ctrl_if
// Purpose    : Bundle between the pipeline datapath and the hazard controller.
//              master : datapath side (drives register ids / controls,
//                       receives forwarding selects, stalls, flushes, counters)
//              slave  : hazard_ctrl side
// Parameters : CNT_W - width of the performance counters
// Revision   : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // Datapath -> controller
  logic [4:0]       rs1D;
  logic [4:0]       rs2D;
  logic [4:0]       rs1E;
  logic [4:0]       rs2E;
  logic [4:0]       rdE;
  logic [4:0]       rdM;
  logic [4:0]       rdW;
  logic             regwriteM;
  logic             regwriteW;
  logic [1:0]       wbselE;
  logic             pcselE;
  logic             mc_startE;

  // Controller -> datapath
  logic [1:0]       forwardAE;
  logic [1:0]       forwardBE;
  logic             stallF;
  logic             stallD;
  logic             stallE;
  logic             flushD;
  logic             flushE;
  logic             bubbleM;
  logic             mc_busy;
  logic             mc_done;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  modport master (
    output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    output regwriteM, regwriteW, wbselE, pcselE, mc_startE,
    input  forwardAE, forwardBE, stallF, stallD, stallE,
    input  flushD, flushE, bubbleM, mc_busy, mc_done,
    input  cnt_stall, cnt_flush
  );

  modport slave (
    input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
    input  regwriteM, regwriteW, wbselE, pcselE, mc_startE,
    output forwardAE, forwardBE, stallF, stallD, stallE,
    output flushD, flushE, bubbleM, mc_busy, mc_done,
    output cnt_stall, cnt_flush
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module     : sat_counter
// Purpose    : Up-counter that increments by one on each cycle with inc=1 and
//              sticks at all-ones instead of wrapping.
// Ports      : clk   - clock, rising edge
//              rst   - asynchronous active-high reset, clears count
//              inc   - count this cycle
//              count - current value (W bits)
// Parameters : W - counter width
// Revision   : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         inc,
  output logic      [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : hazard_ctrl
// Purpose    : Hazard and sequencing controller for the 5-stage RISC-V core.
//              - selects forwarding sources for the two EX operands
//              - detects load-use hazards (stall F/D, bubble into E)
//              - flushes D/E on a taken branch/jump resolved in EX
//              - holds a multi-cycle op in EX for MC_LAT cycles
//              - saturating stall / flush performance counters
// Ports      : clk - pipeline clock, rising edge
//              rst - asynchronous active-high reset
//              hz  - hazard_ctrl_if.slave (register ids, controls, stall /
//                    flush / forward outputs, counters)
// Parameters : MC_LAT - EX occupancy of a multi-cycle op (2..16)
//              CNT_W  - performance counter width
// Revision   : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hazard_ctrl_if.slave  hz
);

  // Reload value: the entry cycle (IDLE) and the final cycle (cnt==0) are
  // both part of the occupancy, so the counter spans MC_LAT-2 extra cycles.
  localparam logic [3:0] C_MC_RELOAD = 4'(MC_LAT - 2);

  hz_state_t  r_state;
  hz_state_t  w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_next_cnt;

  logic       w_mcstall;
  logic       w_mc_busy;
  logic       w_mc_done;
  logic       w_lwstall;

  logic       w_stallF;
  logic       w_stallD;
  logic       w_stallE;
  logic       w_flushD;
  logic       w_flushE;
  logic       w_bubbleM;

  // --------------------------------------------------------------------------
  // Forwarding
  // --------------------------------------------------------------------------
  assign hz.forwardAE = fwd_sel(hz.rs1E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);
  assign hz.forwardBE = fwd_sel(hz.rs2E, hz.rdM, hz.regwriteM, hz.rdW, hz.regwriteW);

  // --------------------------------------------------------------------------
  // Load-use detection: a load in EX whose destination is read in decode
  // --------------------------------------------------------------------------
  assign w_lwstall = (hz.wbselE == WB_MEM) && (hz.rdE != 5'd0) &&
                     ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));

  // --------------------------------------------------------------------------
  // Multi-cycle FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_mcstall    = 1'b0;
    w_mc_busy    = 1'b0;
    w_mc_done    = 1'b0;
    case (r_state)
      IDLE: begin
        if (hz.mc_startE) begin
          w_mcstall    = 1'b1;
          w_mc_busy    = 1'b1;
          w_next_state = BUSY;
          w_next_cnt   = C_MC_RELOAD;
        end
      end
      BUSY: begin
        w_mc_busy = 1'b1;
        if (r_cnt != 4'd0) begin
          w_mcstall  = 1'b1;
          w_next_cnt = r_cnt - 4'd1;
        end else begin
          // Final EX cycle; mc_startE still belongs to the same op here.
          w_mc_done    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Stall / flush resolution
  // A held multi-cycle op dominates everything so it is never killed. Below
  // that, a branch redirect dominates the load-use stall: the instruction in
  // decode is flushed anyway, so stalling F/D would only block the new PC.
  // --------------------------------------------------------------------------
  always_comb begin
    w_stallF  = 1'b0;
    w_stallD  = 1'b0;
    w_stallE  = 1'b0;
    w_flushD  = 1'b0;
    w_flushE  = 1'b0;
    w_bubbleM = 1'b0;
    if (w_mcstall) begin
      w_stallF  = 1'b1;
      w_stallD  = 1'b1;
      w_stallE  = 1'b1;
      w_bubbleM = 1'b1;
    end else begin
      w_flushD = hz.pcselE;
      w_flushE = hz.pcselE | w_lwstall;
      w_stallF = w_lwstall & ~hz.pcselE;
      w_stallD = w_lwstall & ~hz.pcselE;
    end
  end

  assign hz.stallF  = w_stallF;
  assign hz.stallD  = w_stallD;
  assign hz.stallE  = w_stallE;
  assign hz.flushD  = w_flushD;
  assign hz.flushE  = w_flushE;
  assign hz.bubbleM = w_bubbleM;
  assign hz.mc_busy = w_mc_busy;
  assign hz.mc_done = w_mc_done;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
  sat_counter #(.W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stallD),
    .count (hz.cnt_stall)
  );

  sat_counter #(.W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flushD),
    .count (hz.cnt_flush)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module     : tb_hazard_ctrl
// Purpose    : Directed self-checking bench for hazard_ctrl (MC_LAT=4,
//              CNT_W=4). Each step pushes the expected output vector into a
//              scoreboard queue; it is popped and compared mid-cycle.
//              Expected counters are tracked from the expected stallD/flushD.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int MC_LAT = 4;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] C_SAT = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Layout: {fwdA[1:0], fwdB[1:0], stallF, stallD, stallE, flushD, flushE,
  //          bubbleM, mc_busy, mc_done}
  logic [11:0] exp_q[$];
  string       tag_q[$];

  logic [CNT_W-1:0] m_stall = '0;
  logic [CNT_W-1:0] m_flush = '0;

  function automatic logic [11:0] ev(
    input logic [1:0] fa, input logic [1:0] fb,
    input logic sF, input logic sD, input logic sE,
    input logic fD, input logic fE, input logic bM,
    input logic busy, input logic done
  );
    return {fa, fb, sF, sD, sE, fD, fE, bM, busy, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    hz.rs1D = 5'd0; hz.rs2D = 5'd0; hz.rs1E = 5'd0; hz.rs2E = 5'd0;
    hz.rdE  = 5'd0; hz.rdM  = 5'd0; hz.rdW  = 5'd0;
    hz.regwriteM = 1'b0; hz.regwriteW = 1'b0;
    hz.wbselE = 2'b00; hz.pcselE = 1'b0; hz.mc_startE = 1'b0;
  endtask

  // One pipeline cycle: inputs are already driven (#1 after a rising edge).
  task automatic step(input string tag, input logic [11:0] e);
    logic [11:0] exp_v;
    logic [11:0] obs_v;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
    end
    @(negedge clk);
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    obs_v = {hz.forwardAE, hz.forwardBE, hz.stallF, hz.stallD, hz.stallE,
             hz.flushD, hz.flushE, hz.bubbleM, hz.mc_busy, hz.mc_done};
    check(t, 32'(obs_v), 32'(exp_v));
    check({t, "_cnt_stall"}, 32'(hz.cnt_stall), 32'(m_stall));
    check({t, "_cnt_flush"}, 32'(hz.cnt_flush), 32'(m_flush));
    @(posedge clk);
    if (!rst) begin
      if (exp_v[6] && (m_stall != C_SAT)) m_stall = m_stall + 1'b1;
      if (exp_v[4] && (m_flush != C_SAT)) m_flush = m_flush + 1'b1;
    end
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [11:0] e_lu;
  logic [11:0] e_mc;
  logic [11:0] e_done;

  initial begin
    e_lu   = ev(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0, 0);
    e_mc   = ev(2'b00, 2'b00, 1, 1, 1, 0, 0, 1, 1, 0);
    e_done = ev(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);

    clear_inputs();
    rst = 1'b1;
    step("reset", 12'h000);
    rst = 1'b0;
    step("post_reset", 12'h000);

    // Forwarding priority and x0 handling
    hz.rdM = 5'd5; hz.rdW = 5'd5; hz.regwriteM = 1'b1; hz.regwriteW = 1'b1; hz.rs1E = 5'd5;
    step("fwdA_M", ev(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.regwriteM = 1'b0;
    step("fwdA_W", ev(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.rdM = 5'd0; hz.rdW = 5'd0;
    step("fwdA_x0", 12'h000);
    hz.rs2E = 5'd9; hz.rdM = 5'd9; hz.rdW = 5'd9; hz.regwriteM = 1'b1;
    step("fwdB_M", ev(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0));
    hz.regwriteM = 1'b0;
    step("fwdB_W", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));

    // Load-use on rs2D, then the load moves on and forwards from W
    clear_inputs();
    hz.wbselE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    step("lu_stall", e_lu);
    clear_inputs();
    hz.rdM = 5'd7; hz.regwriteM = 1'b1; hz.rs2D = 5'd7;
    step("lu_bubble", 12'h000);
    clear_inputs();
    hz.rdW = 5'd7; hz.regwriteW = 1'b1; hz.rs2E = 5'd7;
    step("lu_fwdB", ev(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0));
    clear_inputs();
    hz.wbselE = 2'b01; hz.rdE = 5'd0;
    step("lu_x0", 12'h000);
    hz.rdE = 5'd3; hz.rs1D = 5'd3;
    step("lu_rs1", e_lu);
    hz.wbselE = 2'b00;
    step("alu_no_lu", 12'h000);

    // Branch overrides a simultaneous load-use
    clear_inputs();
    hz.pcselE = 1'b1; hz.wbselE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    step("br_over_lu", ev(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0, 0));
    clear_inputs();
    step("br_after", 12'h000);

    // Multi-cycle op, held start, back-to-back restart
    hz.mc_startE = 1'b1;
    step("mc_c0", e_mc);
    hz.pcselE = 1'b1; hz.wbselE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    step("mc_c1_suppress", e_mc);
    hz.pcselE = 1'b0; hz.wbselE = 2'b00; hz.rdE = 5'd0; hz.rs2D = 5'd0;
    step("mc_c2", e_mc);
    step("mc_c3_done", e_done);
    step("mc_restart", e_mc);
    step("mc_r1", e_mc);

    // Asynchronous reset while BUSY with cnt==1
    hz.mc_startE = 1'b0;
    rst = 1'b1;
    step("rst_mid_busy", 12'h000);
    rst = 1'b0;
    hz.mc_startE = 1'b1;
    step("post_c0", e_mc);
    step("post_c1", e_mc);
    step("post_c2", e_mc);
    step("post_c3_done", e_done);
    hz.mc_startE = 1'b0;
    step("post_idle", 12'h000);

    // Saturation of the stall counter (CNT_W=4 -> 15)
    hz.wbselE = 2'b01; hz.rdE = 5'd7; hz.rs2D = 5'd7;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      step("sat_stall", e_lu);
    end
    clear_inputs();
    step("sat_end", 12'h000);
    check("cnt_stall_sat", 32'(hz.cnt_stall), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
